// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL opcodes and burst helpers for the N-to-1 merger.
package tilelink_pkg;

    localparam logic [2:0] A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] A_GET              = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;

    localparam int unsigned TL_MAX_BURST_SIZE = 12;

    // Number of A-channel beats a Put of 2^size bytes occupies on a dw-bit bus.
    function automatic int unsigned tl_beats(input int unsigned size, input int unsigned dw);
        int unsigned bytes;
        bytes = dw / 8;
        if (size > TL_MAX_BURST_SIZE || (32'd1 << size) <= bytes)
            return 1;
        return (32'd1 << size) / bytes;
    endfunction

endpackage

// File: rtl/tilelink_n_to_1_if.sv
// TileLink-UL A/D bundle, NP ports wide; port i occupies packed slice i.
interface tilelink_n_to_1_if #(
    parameter int NP    = 1,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int SW    = 4,
    parameter int TL_SZ = 4
);
    logic [NP-1:0]                 a_valid;
    logic [NP-1:0]                 a_ready;
    logic [NP-1:0][2:0]            a_opcode;
    logic [NP-1:0][2:0]            a_param;
    logic [NP-1:0][TL_SZ-1:0]      a_size;
    logic [NP-1:0][SW-1:0]         a_source;
    logic [NP-1:0][TL_AW-1:0]      a_address;
    logic [NP-1:0][TL_DW/8-1:0]    a_mask;
    logic [NP-1:0][TL_DW-1:0]      a_data;
    logic [NP-1:0]                 a_corrupt;

    logic [NP-1:0]                 d_valid;
    logic [NP-1:0]                 d_ready;
    logic [NP-1:0][2:0]            d_opcode;
    logic [NP-1:0][1:0]            d_param;
    logic [NP-1:0][TL_SZ-1:0]      d_size;
    logic [NP-1:0][SW-1:0]         d_source;
    logic [NP-1:0]                 d_denied;
    logic [NP-1:0][TL_DW-1:0]      d_data;
    logic [NP-1:0]                 d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        input  d_ready
    );

endinterface

// File: rtl/tilelink_rr_arbiter.sv
// Round-robin request arbiter with one-hot grant; TILELINK_NTO1_FIXED_PRIORITY_EN
// selects lowest-index fixed priority instead.
module tilelink_rr_arbiter #(
    parameter int N = 2,
    localparam int MI = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    input  logic [MI-1:0] adv_idx,
    output logic [N-1:0]  grant,
    output logic [MI-1:0] grant_idx
);
`ifdef TILELINK_NTO1_FIXED_PRIORITY_EN
    logic unused_adv;
    assign unused_adv = ^{clk, rst_n, adv, adv_idx};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = MI'(i);
            end
        end
    end
`else
    logic [MI-1:0] rr_ptr;
    logic          found;
    int            idx;

    // Scan from rr_ptr upward, wrapping, and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = MI'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (adv)
            rr_ptr <= (32'(adv_idx) == N - 1) ? '0 : adv_idx + 1'b1;
    end
`endif
endmodule

// File: rtl/tilelink_n_to_1.sv
// TileLink-UL N-to-1 merger: arbitrated A channel with Put burst lock, D steered by source MSBs.
// Build option: TILELINK_NTO1_FIXED_PRIORITY_EN (fixed-priority unlocked grant).
module tilelink_n_to_1
    import tilelink_pkg::*;
#(
    parameter int N     = 2,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4
) (
    input logic               tilelink_clock_i,
    input logic               tilelink_reset_ni,
    tilelink_n_to_1_if.slave  master,
    tilelink_n_to_1_if.master slave
);
    localparam int MI = $clog2(N);
    localparam int BW = 13;

    logic                   ao_valid;
    logic [2:0]             ao_opcode, ao_param;
    logic [TL_SZ-1:0]       ao_size;
    logic [TL_RS+MI-1:0]    ao_source;
    logic [TL_AW-1:0]       ao_address;
    logic [TL_DW/8-1:0]     ao_mask;
    logic [TL_DW-1:0]       ao_data;
    logic                   ao_corrupt;

    logic                   ao_free, a_fire, lock, is_put;
    logic [MI-1:0]          lock_idx, arb_idx, g_idx;
    logic [BW-1:0]          beat_cnt, burst_beats;
    logic [N-1:0]           arb_grant, grant, a_rdy;

    assign ao_free = !ao_valid || slave.a_ready[0];

    tilelink_rr_arbiter #(.N(N)) u_arb (
        .clk       (tilelink_clock_i),
        .rst_n     (tilelink_reset_ni),
        .req       (master.a_valid),
        .adv       (a_fire),
        .adv_idx   (g_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign g_idx          = lock ? lock_idx : arb_idx;
    assign grant          = lock ? (N'(1) << lock_idx) : arb_grant;
    assign a_rdy          = ao_free ? grant : '0;
    assign master.a_ready = a_rdy;
    assign a_fire         = |(master.a_valid & a_rdy);
    assign is_put         = (master.a_opcode[g_idx] == A_PUT_FULL_DATA) ||
                            (master.a_opcode[g_idx] == A_PUT_PARTIAL_DATA);
    assign burst_beats    = BW'(tl_beats(32'(master.a_size[g_idx]), TL_DW));

    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            ao_valid   <= 1'b0;
            ao_opcode  <= '0;
            ao_param   <= '0;
            ao_size    <= '0;
            ao_source  <= '0;
            ao_address <= '0;
            ao_mask    <= '0;
            ao_data    <= '0;
            ao_corrupt <= 1'b0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            beat_cnt   <= '0;
        end else if (a_fire) begin
            ao_valid   <= 1'b1;
            ao_opcode  <= master.a_opcode[g_idx];
            ao_param   <= master.a_param[g_idx];
            ao_size    <= master.a_size[g_idx];
            ao_source  <= {g_idx, master.a_source[g_idx]};
            ao_address <= master.a_address[g_idx];
            ao_mask    <= master.a_mask[g_idx];
            ao_data    <= master.a_data[g_idx];
            ao_corrupt <= master.a_corrupt[g_idx];
            // First beat of a multi-beat Put pins the grant until the last beat.
            if (!lock) begin
                if (is_put && burst_beats > BW'(1)) begin
                    lock     <= 1'b1;
                    lock_idx <= g_idx;
                    beat_cnt <= burst_beats - BW'(1);
                end
            end else begin
                beat_cnt <= beat_cnt - BW'(1);
                if (beat_cnt == BW'(1)) lock <= 1'b0;
            end
        end else if (slave.a_ready[0]) begin
            ao_valid <= 1'b0;
        end
    end

    assign slave.a_valid   = ao_valid;
    assign slave.a_opcode  = ao_opcode;
    assign slave.a_param   = ao_param;
    assign slave.a_size    = ao_size;
    assign slave.a_source  = ao_source;
    assign slave.a_address = ao_address;
    assign slave.a_mask    = ao_mask;
    assign slave.a_data    = ao_data;
    assign slave.a_corrupt = ao_corrupt;

    logic [MI-1:0]             dm;
    logic                      dm_ok, d_rdy, d_load;
    logic [N-1:0]              md_valid, md_denied, md_corrupt;
    logic [N-1:0][2:0]         md_opcode;
    logic [N-1:0][1:0]         md_param;
    logic [N-1:0][TL_SZ-1:0]   md_size;
    logic [N-1:0][TL_RS-1:0]   md_source;
    logic [N-1:0][TL_DW-1:0]   md_data;

    // Indices beyond N-1 (non-power-of-2 N) are swallowed so the slave never stalls.
    assign dm            = slave.d_source[0][TL_RS+MI-1:TL_RS];
    assign dm_ok         = 32'(dm) < N;
    assign d_rdy         = dm_ok ? (!md_valid[dm] || master.d_ready[dm]) : 1'b1;
    assign slave.d_ready = d_rdy;
    assign d_load        = slave.d_valid[0] && d_rdy && dm_ok;

    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            md_valid   <= '0;
            md_opcode  <= '0;
            md_param   <= '0;
            md_size    <= '0;
            md_source  <= '0;
            md_denied  <= '0;
            md_data    <= '0;
            md_corrupt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (d_load && dm == MI'(i)) begin
                    md_valid[i]   <= 1'b1;
                    md_opcode[i]  <= slave.d_opcode[0];
                    md_param[i]   <= slave.d_param[0];
                    md_size[i]    <= slave.d_size[0];
                    md_source[i]  <= slave.d_source[0][TL_RS-1:0];
                    md_denied[i]  <= slave.d_denied[0];
                    md_data[i]    <= slave.d_data[0];
                    md_corrupt[i] <= slave.d_corrupt[0];
                end else if (master.d_ready[i]) begin
                    md_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign master.d_valid   = md_valid;
    assign master.d_opcode  = md_opcode;
    assign master.d_param   = md_param;
    assign master.d_size    = md_size;
    assign master.d_source  = md_source;
    assign master.d_denied  = md_denied;
    assign master.d_data    = md_data;
    assign master.d_corrupt = md_corrupt;

endmodule

// File: tb/tb_tilelink_n_to_1.sv
// Bench for tilelink_n_to_1 (N=3): directed scenarios plus randomized traffic against a transaction-level model.
module tb_tilelink_n_to_1;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RS = 4;
    localparam int SZ = 4;
    localparam int MI = 2;
    localparam int SW = RS + MI;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tilelink_n_to_1_if #(.NP(N), .TL_DW(DW), .TL_AW(AW), .SW(RS), .TL_SZ(SZ)) mif ();
    tilelink_n_to_1_if #(.NP(1), .TL_DW(DW), .TL_AW(AW), .SW(SW), .TL_SZ(SZ)) sif ();

    tilelink_n_to_1 #(.N(N), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
        .tilelink_clock_i  (clk),
        .tilelink_reset_ni (rst_n),
        .master            (mif),
        .slave             (sif)
    );

    typedef struct packed {
        logic [2:0] op; logic [2:0] prm; logic [3:0] sz; logic [5:0] src;
        logic [31:0] addr; logic [3:0] mask; logic [31:0] data; logic cor;
    } a_beat_t;
    typedef struct packed {
        logic [2:0] op; logic [1:0] prm; logic [3:0] sz; logic [3:0] src;
        logic den; logic [31:0] data; logic cor;
    } d_beat_t;

    int checks = 0;
    int errors = 0;

    // Model state: slave A register, arbitration pointer, burst owner, per-master D slots.
    bit      m_sa_valid;
    a_beat_t m_sa;
    int      m_ptr, m_owner, m_left;
    bit      m_md_valid [N];
    d_beat_t m_md [N];
    int      last_g;
    int      fired_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sa_valid = 1'b0;
        m_sa       = '0;
        m_ptr      = 0;
        m_owner    = -1;
        m_left     = 0;
        last_g     = -1;
        for (int i = 0; i < N; i++) begin
            m_md_valid[i] = 1'b0;
            m_md[i]       = '0;
        end
    endtask

    function automatic int pick();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < N; k++)
            if (mif.a_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic a_beat_t dut_a();
        return {sif.a_opcode[0], sif.a_param[0], sif.a_size[0], sif.a_source[0],
                sif.a_address[0], sif.a_mask[0], sif.a_data[0], sif.a_corrupt[0]};
    endfunction

    function automatic d_beat_t dut_d(input int i);
        return {mif.d_opcode[i], mif.d_param[i], mif.d_size[i], mif.d_source[i],
                mif.d_denied[i], mif.d_data[i], mif.d_corrupt[i]};
    endfunction

    task automatic check_cycle();
        int g, dm, sz;
        bit free, fire, sdr;
        logic [N-1:0] er, ev;
        free = !m_sa_valid || sif.a_ready[0];
        g    = pick();
        er   = '0;
        if (free && g >= 0) er[g] = 1'b1;
        chk("a_ready", 128'(mif.a_ready), 128'(er));
        chk("sa_valid", 128'(sif.a_valid[0]), 128'(m_sa_valid));
        if (m_sa_valid) chk("sa_beat", 128'(dut_a()), 128'(m_sa));
        if (sif.a_valid[0] && sif.a_ready[0]) fired_q.push_back(int'(sif.a_source[0][5:4]));
        dm  = int'(sif.d_source[0][5:4]);
        sdr = (dm >= N) ? 1'b1 : (!m_md_valid[dm] || mif.d_ready[dm]);
        chk("sd_ready", 128'(sif.d_ready[0]), 128'(sdr));
        ev = '0;
        for (int i = 0; i < N; i++) ev[i] = m_md_valid[i];
        chk("md_valid", 128'(mif.d_valid), 128'(ev));
        for (int i = 0; i < N; i++)
            if (m_md_valid[i]) chk("md_beat", 128'(dut_d(i)), 128'(m_md[i]));

        fire   = (g >= 0) && mif.a_valid[g] && free;
        last_g = fire ? g : -1;
        if (fire) begin
            m_sa = {mif.a_opcode[g], mif.a_param[g], mif.a_size[g], 2'(g), mif.a_source[g],
                    mif.a_address[g], mif.a_mask[g], mif.a_data[g], mif.a_corrupt[g]};
            m_sa_valid = 1'b1;
            m_ptr = (g + 1) % N;
            sz = int'(mif.a_size[g]);
            if (m_owner < 0) begin
                if (mif.a_opcode[g] <= 3'd1 && sz <= 12 && (1 << sz) > DW / 8) begin
                    m_owner = g;
                    m_left  = (1 << sz) / (DW / 8) - 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end else if (sif.a_ready[0]) begin
            m_sa_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (sif.d_valid[0] && sdr && dm == i) begin
                m_md[i] = {sif.d_opcode[0], sif.d_param[0], sif.d_size[0], sif.d_source[0][3:0],
                           sif.d_denied[0], sif.d_data[0], sif.d_corrupt[0]};
                m_md_valid[i] = 1'b1;
            end else if (mif.d_ready[i]) begin
                m_md_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        #2;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.a_valid = '0; mif.a_opcode = '0; mif.a_param = '0; mif.a_size = '0;
        mif.a_source = '0; mif.a_address = '0; mif.a_mask = '0; mif.a_data = '0;
        mif.a_corrupt = '0; mif.d_ready = '1;
        sif.a_ready = 1'b1; sif.d_valid = 1'b0; sif.d_opcode = '0; sif.d_param = '0;
        sif.d_size = '0; sif.d_source = '0; sif.d_denied = '0; sif.d_data = '0; sif.d_corrupt = '0;
    endtask

    task automatic set_a(input int i, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input logic [31:0] addr, input logic [31:0] data);
        mif.a_opcode[i] = op; mif.a_param[i] = 3'd0; mif.a_size[i] = sz;
        mif.a_source[i] = src; mif.a_address[i] = addr; mif.a_mask[i] = 4'hf;
        mif.a_data[i] = data; mif.a_corrupt[i] = 1'b0; mif.a_valid[i] = 1'b1;
    endtask

    task automatic set_d(input logic [2:0] op, input logic [5:0] src, input logic [31:0] data);
        sif.d_opcode = op; sif.d_param = 2'd0; sif.d_size = 4'd2; sif.d_source = src;
        sif.d_denied = 1'b0; sif.d_data = data; sif.d_corrupt = 1'b0; sif.d_valid = 1'b1;
    endtask

    task automatic rand_a(input int i);
        int r;
        r = int'($urandom % 3);
        mif.a_opcode[i]  = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4;
        mif.a_param[i]   = 3'($urandom);
        mif.a_size[i]    = ($urandom % 8 == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 6);
        mif.a_source[i]  = 4'($urandom);
        mif.a_address[i] = $urandom;
        mif.a_mask[i]    = 4'($urandom);
        mif.a_data[i]    = $urandom;
        mif.a_corrupt[i] = 1'($urandom);
        mif.a_valid[i]   = 1'b1;
    endtask

    task automatic rand_d();
        sif.d_opcode  = 3'($urandom % 2);
        sif.d_param   = 2'($urandom);
        sif.d_size    = 4'($urandom);
        sif.d_source  = {2'($urandom % 4), 4'($urandom)};
        sif.d_denied  = 1'($urandom);
        sif.d_data    = $urandom;
        sif.d_corrupt = 1'($urandom);
        sif.d_valid   = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int c1;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sa_valid", 128'(sif.a_valid), 128'(0));
        chk("rst_md_valid", 128'(mif.d_valid), 128'(0));
        chk("rst_a_ready", 128'(mif.a_ready), 128'(0));
        chk("rst_sa_addr", 128'(sif.a_address), 128'(0));
        rst_n = 1'b1;

        // Two simultaneous Gets, pointer at 0.
        set_a(0, 3'd4, 4'd2, 4'd3, 32'h100, 32'h0);
        set_a(1, 3'd4, 4'd2, 4'd5, 32'h200, 32'h0);
        step();
        mif.a_valid[0] = 1'b0;
        chk("t2_src0", 128'(sif.a_source[0]), 128'(6'h03));
        chk("t2_addr0", 128'(sif.a_address[0]), 128'(32'h100));
        step();
        mif.a_valid[1] = 1'b0;
        chk("t2_src1", 128'(sif.a_source[0]), 128'(6'h15));
        chk("t2_addr1", 128'(sif.a_address[0]), 128'(32'h200));
        set_a(0, 3'd4, 4'd2, 4'd0, 32'h180, 32'h0);
        step();
        mif.a_valid[0] = 1'b0;
        step();

        // 4-beat PutFull from master 1 while master 0 waits.
        fired_q.delete();
        set_a(0, 3'd4, 4'd2, 4'd1, 32'h300, 32'h0);
        set_a(1, 3'd0, 4'd4, 4'd2, 32'h400, 32'ha0);
        c1 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_g == 1) begin
                c1++;
                if (c1 == 4) mif.a_valid[1] = 1'b0;
                else mif.a_data[1] = mif.a_data[1] + 32'd1;
            end else if (last_g == 0) begin
                mif.a_valid[0] = 1'b0;
            end
        end
        chk("t3_count", 128'(fired_q.size()), 128'(5));
        if (fired_q.size() == 5) begin
            for (int k = 0; k < 4; k++) chk("t3_burst_owner", 128'(fired_q[k]), 128'(1));
            chk("t3_after_burst", 128'(fired_q[4]), 128'(0));
        end

        // Downstream backpressure holds the A register.
        set_a(2, 3'd4, 4'd2, 4'd9, 32'h500, 32'h0);
        sif.a_ready = 1'b0;
        step();
        set_a(2, 3'd4, 4'd2, 4'd9, 32'h600, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_ready", 128'(mif.a_ready), 128'(0));
            chk("t4_addr", 128'(sif.a_address[0]), 128'(32'h500));
        end
        sif.a_ready = 1'b1;
        step();
        mif.a_valid[2] = 1'b0;
        chk("t4_addr2", 128'(sif.a_address[0]), 128'(32'h600));
        step();

        // D steering with a stalled master 1.
        mif.d_ready = 3'b101;
        set_d(3'd1, 6'h17, 32'hd1);
        step();
        chk("t5_valid1", 128'(mif.d_valid[1]), 128'(1));
        chk("t5_src1", 128'(mif.d_source[1]), 128'(4'h7));
        set_d(3'd1, 6'h17, 32'hd2);
        #1;
        chk("t5_stall", 128'(sif.d_ready), 128'(0));
        step();
        set_d(3'd1, 6'h05, 32'hd3);
        #1;
        chk("t5_other", 128'(sif.d_ready), 128'(1));
        step();
        chk("t5_valid0", 128'(mif.d_valid), 128'(3'b011));
        chk("t5_data0", 128'(mif.d_data[0]), 128'(32'hd3));
        chk("t5_data1", 128'(mif.d_data[1]), 128'(32'hd1));
        sif.d_valid = 1'b0;
        mif.d_ready = '1;
        step();
        step();

        // Out-of-range D index is discarded.
        set_d(3'd0, 6'h3a, 32'hee);
        #1;
        chk("t6_ready", 128'(sif.d_ready), 128'(1));
        step();
        sif.d_valid = 1'b0;
        chk("t6_none", 128'(mif.d_valid), 128'(0));
        step();

        // Reset in the middle of an 8-beat burst.
        set_a(0, 3'd0, 4'd5, 4'd1, 32'h700, 32'h70);
        set_a(2, 3'd4, 4'd2, 4'd4, 32'h900, 32'h0);
        set_d(3'd1, 6'h02, 32'hd7);
        step();
        sif.d_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t7_sa_valid", 128'(sif.a_valid), 128'(0));
        chk("t7_md_valid", 128'(mif.d_valid), 128'(0));
        model_reset();
        set_a(0, 3'd4, 4'd2, 4'd2, 32'h800, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t7_grant", 128'(mif.a_ready), 128'(3'b001));
        step();
        mif.a_valid[0] = 1'b0;
        chk("t7_src", 128'(sif.a_source[0]), 128'(6'h02));
        step();
        mif.a_valid[2] = 1'b0;
        chk("t7_src2", 128'(sif.a_source[0]), 128'(6'h24));
        step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            sif.a_ready = ($urandom % 4) != 0;
            mif.d_ready = 3'($urandom);
            if ($urandom % 2 == 0) rand_d();
            else sif.d_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!mif.a_valid[i] && $urandom % 3 == 0) rand_a(i);
                else if (mif.a_valid[i] && $urandom % 32 == 0) mif.a_valid[i] = 1'b0;
            end
            step();
            if (last_g >= 0) begin
                if ($urandom % 4 == 0) mif.a_valid[last_g] = 1'b0;
                else if (m_owner == last_g) mif.a_data[last_g] = $urandom;
                else rand_a(last_g);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
